// File: rtl/slv_guard_rst_seq.sv
// Reset sequencer behind the subordinate guard: isolates and drains the subordinate, pulses its reset,
// waits for its acknowledge and then hands reset-clear back to the guard (sticky error on ack timeout).
`timescale 1ns/1ps
module slv_guard_rst_seq #(
  parameter int DrainCycles = 8,
  parameter int RstCycles   = 16,
  parameter int AckTimeout  = 256,
  parameter int CntWidth    = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rst_req_i,
  input  logic       sw_clr_i,
  input  logic       slv_rst_ack_i,
  output logic       isolate_o,
  output logic       slv_rst_o,
  output logic       rst_stat_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [7:0] rst_cnt_o
);

  generate
    if (DrainCycles < 1 || RstCycles < 1 || AckTimeout < 1) begin : g_bad_min
      $error("slv_guard_rst_seq: DrainCycles, RstCycles and AckTimeout must all be >= 1");
    end
    if (DrainCycles > 2**CntWidth || RstCycles > 2**CntWidth || AckTimeout > 2**CntWidth) begin : g_bad_width
      $error("slv_guard_rst_seq: CntWidth too narrow for the configured cycle counts");
    end
  endgenerate

  // Terminal counts: each phase ends on the cycle its counter reaches length-1.
  localparam logic [CntWidth-1:0] DRAIN_LAST = CntWidth'(DrainCycles - 1);
  localparam logic [CntWidth-1:0] RST_LAST   = CntWidth'(RstCycles - 1);
  localparam logic [CntWidth-1:0] ACK_LAST   = CntWidth'(AckTimeout - 1);
  localparam logic [CntWidth-1:0] CNT_ONE    = CntWidth'(1);

  typedef enum logic [2:0] {
    IDLE,
    ISOLATE,
    RESET,
    WAIT_ACK,
    CLEAR,
    ERROR
  } state_t;

  state_t              state_reg;
  logic [CntWidth-1:0] cnt_reg;
  logic [7:0]          rst_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rst_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rst_req_i) begin
            state_reg <= ISOLATE;
            cnt_reg   <= '0;
          end
        end
        ISOLATE: begin
          if (cnt_reg == DRAIN_LAST) begin
            state_reg <= RESET;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        RESET: begin
          if (cnt_reg == RST_LAST) begin
            state_reg <= WAIT_ACK;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        WAIT_ACK: begin
          // An ack arriving on the final timeout cycle still counts as success.
          if (slv_rst_ack_i) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
            if (rst_cnt_reg != 8'hFF) begin
              rst_cnt_reg <= rst_cnt_reg + 8'd1;
            end
          end else if (cnt_reg == ACK_LAST) begin
            state_reg <= ERROR;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        CLEAR: begin
          if (!rst_req_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end
        end
        ERROR: begin
          if (sw_clr_i) begin
            state_reg <= ISOLATE;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Moore outputs: decoded from the state register only.
  assign isolate_o  = (state_reg != IDLE);
  assign busy_o     = (state_reg != IDLE);
  assign slv_rst_o  = (state_reg == RESET);
  assign rst_stat_o = (state_reg == CLEAR);
  assign err_o      = (state_reg == ERROR);
  assign rst_cnt_o  = rst_cnt_reg;

endmodule

// File: tb/tb_slv_guard_rst_seq.sv
// Bench for slv_guard_rst_seq: a reset/idle vector table, then sequences whose expected output
// timelines are laid out phase by phase from the sequencing rules and compared cycle by cycle.
`timescale 1ns/1ps
module tb_slv_guard_rst_seq;

  localparam int D = 8;
  localparam int R = 16;
  localparam int T = 256;

  // Output flag groups {isolate, slv_rst, rst_stat, busy, err} per externally visible phase.
  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_ISO  = 5'b10010;
  localparam logic [4:0] S_RST  = 5'b11010;
  localparam logic [4:0] S_WAIT = 5'b10010;
  localparam logic [4:0] S_CLR  = 5'b10110;
  localparam logic [4:0] S_ERR  = 5'b10011;

  logic       clk_i = 1'b0;
  logic       rst_i, rst_req_i, sw_clr_i, slv_rst_ack_i;
  logic       isolate_o, slv_rst_o, rst_stat_o, busy_o, err_o;
  logic [7:0] rst_cnt_o;
  logic [12:0] out_vec;

  slv_guard_rst_seq #(
    .DrainCycles(D), .RstCycles(R), .AckTimeout(T), .CntWidth(10)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rst_req_i(rst_req_i), .sw_clr_i(sw_clr_i),
    .slv_rst_ack_i(slv_rst_ack_i), .isolate_o(isolate_o), .slv_rst_o(slv_rst_o),
    .rst_stat_o(rst_stat_o), .busy_o(busy_o), .err_o(err_o), .rst_cnt_o(rst_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  assign out_vec = {isolate_o, slv_rst_o, rst_stat_o, busy_o, err_o, rst_cnt_o};

  typedef struct {
    logic rst, req, clr, ack;
    logic [12:0] exp;
  } vec_t;

  typedef struct {
    logic req, clr, ack;
    logic [12:0] exp;
  } step_t;

  vec_t  tbl[9];
  step_t step_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    m_cnt = 0;   // completed sequences as the reference sees them
  int    iso_rise, rst_first, rst_last, stat_rise, idle_back, err_rise, err_fall;

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One step = inputs driven during a cycle and the outputs required after the next edge.
  task automatic push(input logic req, input logic clr, input logic ack, input logic [4:0] st);
    step_t s;
    s.req = req; s.clr = clr; s.ack = ack;
    s.exp = {st, 8'(m_cnt)};
    step_q.push_back(s);
  endtask

  // Everything after entering ISOLATE: drain, reset pulse, then ack after 'a' cycles of waiting
  // (a >= T means the subordinate never answers). 'hold' keeps ack high through drain and reset.
  task automatic add_body(input int a, input bit hold);
    for (int i = 0; i < D; i++) push(rb(), rb(), hold ? 1'b1 : rb(), (i == D - 1) ? S_RST : S_ISO);
    for (int i = 0; i < R; i++) push(rb(), rb(), hold ? 1'b1 : rb(), (i == R - 1) ? S_WAIT : S_RST);
    if (a < T) begin
      for (int i = 0; i < a; i++) push(rb(), rb(), 1'b0, S_WAIT);
      if (m_cnt < 255) m_cnt++;
      push(rb(), rb(), 1'b1, S_CLR);
    end else begin
      for (int i = 0; i < T - 1; i++) push(rb(), rb(), 1'b0, S_WAIT);
      push(rb(), rb(), 1'b0, S_ERR);
    end
  endtask

  // Full sequence from IDLE: request, body, optional error + retry after s cycles with ack delay a2,
  // then hold the request for q cycles in CLEAR before releasing it.
  task automatic build_seq(input int a, input int q, input int s, input int a2, input bit hold);
    push(1'b1, rb(), rb(), S_ISO);
    add_body(a, hold);
    if (a >= T) begin
      for (int i = 0; i < s; i++) push(rb(), 1'b0, rb(), S_ERR);
      push(rb(), 1'b1, rb(), S_ISO);
      add_body((a2 < T) ? a2 : T - 1, hold);
    end
    for (int i = 0; i < q; i++) push(1'b1, rb(), rb(), S_CLR);
    push(1'b0, rb(), rb(), S_IDLE);
    push(1'b0, rb(), rb(), S_IDLE);
  endtask

  task automatic run_q(input string tag);
    step_t s;
    int cyc = 0;
    int fails0 = n_fail;
    iso_rise = -1; rst_first = -1; rst_last = -1; stat_rise = -1;
    idle_back = -1; err_rise = -1; err_fall = -1;
    while (step_q.size() > 0) begin
      s = step_q.pop_front();
      rst_req_i = s.req; sw_clr_i = s.clr; slv_rst_ack_i = s.ack;
      tick();
      cyc++;
      n_chk++;
      if (out_vec !== s.exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: outputs %h, required %h", tag, cyc, out_vec, s.exp);
      end
      if (isolate_o && iso_rise < 0) iso_rise = cyc;
      if (slv_rst_o) begin
        if (rst_first < 0) rst_first = cyc;
        rst_last = cyc;
      end
      if (rst_stat_o && stat_rise < 0) stat_rise = cyc;
      if (stat_rise >= 0 && !busy_o && idle_back < 0) idle_back = cyc;
      if (err_o && err_rise < 0) err_rise = cyc;
      if (err_rise >= 0 && !err_o && err_fall < 0) err_fall = cyc;
    end
    sw_clr_i = 1'b0; slv_rst_ack_i = 1'b0;
    $display("seq %s: %0d cycles, rst_cnt=%0d, %0d new failures", tag, cyc, rst_cnt_o, n_fail - fails0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, q, s, a2, r;
    // rst, req, clr, ack -> required outputs
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, {S_IDLE, 8'd0}};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, {S_IDLE, 8'd0}};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, {S_IDLE, 8'd0}};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, {S_IDLE, 8'd0}};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, {S_IDLE, 8'd0}};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, {S_ISO,  8'd0}};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, {S_ISO,  8'd0}};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, {S_IDLE, 8'd0}};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, {S_IDLE, 8'd0}};

    rst_i = 1'b1; rst_req_i = 1'b1; sw_clr_i = 1'b0; slv_rst_ack_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rst_i = tbl[i].rst; rst_req_i = tbl[i].req; sw_clr_i = tbl[i].clr; slv_rst_ack_i = tbl[i].ack;
      tick();
      n_chk++;
      if (out_vec !== tbl[i].exp) begin
        n_fail++;
        $display("FAIL vector %0d: outputs %h, required %h", i, out_vec, tbl[i].exp);
      end else begin
        $display("vector %0d: outputs %h", i, out_vec);
      end
    end
    sw_clr_i = 1'b0; slv_rst_ack_i = 1'b0;
    m_cnt = 0;

    // Nominal: ack 5 cycles into WAIT_ACK, request released 2 cycles after rst_stat rises.
    build_seq(5, 2, 0, 0, 1'b0);
    run_q("nominal");
    check("nominal_iso_rise", iso_rise, 1);
    check("nominal_rst_first", rst_first, 9);
    check("nominal_rst_last", rst_last, 24);
    check("nominal_stat_rise", stat_rise, 31);
    check("nominal_idle_back", idle_back, 34);
    check("nominal_rst_cnt", int'(rst_cnt_o), 1);

    // Timeout into ERROR, then software retry after 3 cycles with a prompt ack.
    build_seq(T, 0, 3, 4, 1'b0);
    run_q("timeout_retry");
    check("timeout_err_rise", err_rise, 25 + T);
    check("retry_err_fall", err_fall, 25 + T + 4);
    check("retry_rst_cnt", int'(rst_cnt_o), 2);

    // Ack on the very last timeout cycle, with ack held high through drain and reset.
    build_seq(T - 1, 1, 0, 0, 1'b1);
    run_q("ack_race");
    check("race_no_err", err_rise, -1);
    check("race_stat_rise", stat_rise, 25 + T);

    for (int n = 0; n < 20; n++) begin
      r  = $urandom_range(9, 0);
      a  = (r < 3) ? T : (r == 3) ? T - 1 : $urandom_range(20, 0);
      q  = $urandom_range(4, 0);
      s  = $urandom_range(6, 0);
      a2 = $urandom_range(40, 0);
      build_seq(a, q, s, a2, r == 4);
      run_q($sformatf("random_%0d", n));
    end

    // Reset asserted in the middle of the reset pulse.
    rst_req_i = 1'b1;
    for (int i = 0; i < D + 3; i++) tick();
    check("midrst_in_reset", int'(slv_rst_o), 1);
    rst_i = 1'b1;
    tick();
    check("midrst_slv_rst", int'(slv_rst_o), 0);
    check("midrst_isolate", int'(isolate_o), 0);
    check("midrst_rst_cnt", int'(rst_cnt_o), 0);
    rst_i = 1'b0; rst_req_i = 1'b0;
    tick();
    check("midrst_idle", int'(busy_o), 0);
    m_cnt = 0;

    for (int n = 0; n < 255; n++) begin
      build_seq(0, 0, 0, 0, 1'b0);
      run_q($sformatf("sat_%0d", n));
    end
    check("sat_reach_ff", int'(rst_cnt_o), 255);
    build_seq(2, 1, 0, 0, 1'b0);
    run_q("sat_extra");
    check("sat_hold_ff", int'(rst_cnt_o), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
